// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRA) for the EX stage: one bit position per clock,
// start/busy/done handshake so the hazard unit can stall the front of the pipe.
module shift_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               arith,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    logic               arith_q;
    logic               sign_q;

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (count == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            work     <= '0;
            count    <= '0;
            arith_q  <= 1'b0;
            sign_q   <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work    <= data_in;
                        count   <= shamt;
                        arith_q <= arith;
                        sign_q  <= data_in[WIDTH-1];
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        // Vacated MSB is sign fill only for arithmetic shifts.
                        work  <= {arith_q & sign_q, work[WIDTH-1:1]};
                        count <= count - 1'b1;
                    end else begin
                        data_out <= work;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decoded straight from the state register, so busy has no input-to-output path.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed/table-driven bench for shift_right_seq: results, done/busy timing,
// ignored mid-operation starts, reset abort, and a short randomized run.
module tb_shift_right_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        arith;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int checks;
    int failures;
    int starts_issued;
    int dones_seen;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    shift_right_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .arith    (arith),
        .data_in  (data_in),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle before start"}, {31'd0, busy}, 32'd0);
    endtask

    // Called at the negedge after edge E(k0); samples each negedge until busy drops.
    task automatic monitor(input int k0, output int done_k, output int done_n,
                           output int busy_n, output bit finished);
        done_k   = -1;
        done_n   = 0;
        busy_n   = 0;
        finished = 1'b0;
        for (int k = k0; k < k0 + 80; k++) begin
            if (k > k0) @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                dones_seen++;
                if (done_k < 0) done_k = k;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] s,
                          input logic a, input logic [31:0] exp);
        int done_k, done_n, busy_n;
        bit finished;
        wait_idle(name);
        data_in = d;
        shamt   = s;
        arith   = a;
        start   = 1'b1;
        @(posedge clk);
        starts_issued++;
        @(negedge clk);
        // Scramble operands after acceptance; they must have no effect.
        start   = 1'b0;
        data_in = ~d;
        shamt   = ~s;
        arith   = ~a;
        monitor(0, done_k, done_n, busy_n, finished);
        check({name, " finished"}, {31'd0, finished}, 32'd1);
        check({name, " data_out"}, data_out, exp);
        check({name, " done cycle"}, 32'(done_k), 32'(s) + 32'd1);
        check({name, " done pulses"}, 32'(done_n), 32'd1);
        check({name, " busy cycles"}, 32'(busy_n), 32'(s) + 32'd2);
    endtask

    initial begin
        int done_k, done_n, busy_n, n;
        bit finished;
        logic [31:0] rd;
        logic [4:0]  rs;
        logic        ra;
        logic [31:0] rexp;

        checks        = 0;
        failures      = 0;
        starts_issued = 0;
        dones_seen    = 0;

        vecs[0]  = '{"sra 80000000 by 4",  32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000};
        vecs[1]  = '{"srl ffffffff by 31", 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001};
        vecs[2]  = '{"sra ffffffff by 31", 32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[3]  = '{"srl 12345678 by 0",  32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
        vecs[4]  = '{"sra 12345678 by 0",  32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678};
        vecs[5]  = '{"sra 40000000 by 10", 32'h4000_0000, 5'd10, 1'b1, 32'h0010_0000};
        vecs[6]  = '{"srl deadbeef by 1",  32'hDEAD_BEEF, 5'd1,  1'b0, 32'h6F56_DF77};
        vecs[7]  = '{"sra deadbeef by 4",  32'hDEAD_BEEF, 5'd4,  1'b1, 32'hFDEA_DBEE};
        vecs[8]  = '{"srl 80000000 by 31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
        vecs[9]  = '{"sra 7fffffff by 30", 32'h7FFF_FFFF, 5'd30, 1'b1, 32'h0000_0001};
        vecs[10] = '{"srl f0f0f0f0 by 8",  32'hF0F0_F0F0, 5'd8,  1'b0, 32'h00F0_F0F0};
        vecs[11] = '{"sra f0f0f0f0 by 8",  32'hF0F0_F0F0, 5'd8,  1'b1, 32'hFFF0_F0F0};

        reset   = 1'b1;
        start   = 1'b0;
        arith   = 1'b0;
        data_in = '0;
        shamt   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset data_out", data_out, 32'd0);

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].d, vecs[i].s, vecs[i].a, vecs[i].exp);

        // A start raised mid-operation must be ignored.
        wait_idle("ignore");
        data_in = 32'h0000_0100;
        shamt   = 5'd8;
        arith   = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        starts_issued++;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        data_in = 32'hDEAD_BEEF;
        shamt   = 5'd1;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        monitor(2, done_k, done_n, busy_n, finished);
        check("ignore finished", {31'd0, finished}, 32'd1);
        check("ignore data_out", data_out, 32'h0000_0001);
        check("ignore done pulses", 32'(done_n), 32'd1);
        check("ignore done cycle", 32'(done_k), 32'd9);
        run_op("after ignore srl deadbeef by 1", 32'hDEAD_BEEF, 5'd1, 1'b0, 32'h6F56_DF77);

        // Reset mid-operation aborts with no done pulse.
        wait_idle("abort");
        data_in = 32'h4000_0000;
        shamt   = 5'd10;
        arith   = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort data_out", data_out, 32'd0);
        n = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort no done", 32'(n), 32'd0);
        run_op("after abort sra 40000000 by 10", 32'h4000_0000, 5'd10, 1'b1, 32'h0010_0000);

        // Reset and start on the same edge: reset wins.
        reset   = 1'b1;
        start   = 1'b1;
        data_in = 32'h1234_5678;
        shamt   = 5'd3;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("reset+start busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("reset+start still idle", {31'd0, busy}, 32'd0);
        check("reset+start data_out", data_out, 32'd0);

        // Randomized back-to-back operations against the language shift operators.
        starts_issued = 0;
        dones_seen    = 0;
        for (int i = 0; i < 20; i++) begin
            rd   = $urandom;
            rs   = 5'($urandom_range(0, 31));
            ra   = 1'($urandom_range(0, 1));
            rexp = ra ? 32'($signed(rd) >>> rs) : (rd >> rs);
            run_op($sformatf("rand%0d %h %s %0d", i, rd, ra ? "sra" : "srl", rs), rd, rs, ra, rexp);
        end
        check("rand done count", 32'(dones_seen), 32'(starts_issued));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
